// File: rtl/cache_unit.sv
// cache_unit: 2-way set-associative, write-through, allocate-on-write cache
// with one data word per line and one LRU bit per set.
//
// Ports:
//   clk   - single clock, all state changes on its rising edge
//   rst   - synchronous active-high reset; clears valid and LRU bits
//   addr  - word address (index = low SET_BITS bits, tag = the rest)
//   data  - bidirectional bus: write data when we=1, driven by the cache
//           only during a read (oe=1, we=0), high-Z otherwise
//   we    - write/allocate strobe (has priority over oe)
//   oe    - read enable
//   found - combinational hit flag for the current addr
module cache_unit #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16,
  parameter int SET_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  we,
  input  logic                  oe,
  output logic                  found
);

  localparam int TAG_W    = ADDR_WIDTH - SET_BITS;
  localparam int NUM_SETS = 1 << SET_BITS;

  // Per set: bit w of valid is way w; lru names the least-recently-used way.
  logic [1:0]            valid_q [NUM_SETS];
  logic [1:0]            valid_d [NUM_SETS];
  logic [NUM_SETS-1:0]   lru_q;
  logic [NUM_SETS-1:0]   lru_d;
  logic [TAG_W-1:0]      tag_q   [NUM_SETS][2];
  logic [TAG_W-1:0]      tag_d   [NUM_SETS][2];
  logic [DATA_WIDTH-1:0] word_q  [NUM_SETS][2];
  logic [DATA_WIDTH-1:0] word_d  [NUM_SETS][2];

  logic [SET_BITS-1:0]   idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit0;
  logic                  hit1;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_way;

  assign idx = addr[SET_BITS-1:0];
  assign tag = addr[ADDR_WIDTH-1:SET_BITS];

  always_comb begin
    hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
    hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
    found   = hit0 || hit1;
    rd_word = '0;
    if (hit0) begin
      rd_word = word_q[idx][0];
    end else if (hit1) begin
      rd_word = word_q[idx][1];
    end
  end

  // The cache owns the bus only for a pure read; a write keeps it released.
  assign data = (oe && !we) ? rd_word : {DATA_WIDTH{1'bz}};

  always_comb begin
    valid_d = valid_q;
    lru_d   = lru_q;
    tag_d   = tag_q;
    word_d  = word_q;
    wr_way  = 1'b0;

    if (we) begin
      // Hit way if any; otherwise first invalid way, else the LRU way.
      if (hit0) begin
        wr_way = 1'b0;
      end else if (hit1) begin
        wr_way = 1'b1;
      end else if (!valid_q[idx][0]) begin
        wr_way = 1'b0;
      end else if (!valid_q[idx][1]) begin
        wr_way = 1'b1;
      end else begin
        wr_way = lru_q[idx];
      end
      valid_d[idx][wr_way] = 1'b1;
      tag_d[idx][wr_way]   = tag;
      word_d[idx][wr_way]  = data;
      lru_d[idx]           = ~wr_way;
    end else if (oe && found) begin
      lru_d[idx] = hit0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '{default: '0};
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

  // Tag and data arrays are not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q  <= tag_d;
      word_q <= word_d;
    end
  end

endmodule

// File: tb/tb_cache_unit.sv
// tb_cache_unit: directed self-checking bench for cache_unit.
module tb_cache_unit;

  logic        clk;
  logic        rst;
  logic [13:0] addr;
  wire  [15:0] data_bus;
  logic        we;
  logic        oe;
  logic        found;
  logic        drv_en;
  logic [15:0] drv_val;

  int n_tests;
  int n_fail;

  assign data_bus = drv_en ? drv_val : 16'bz;

  cache_unit #(
    .ADDR_WIDTH(14),
    .DATA_WIDTH(16),
    .SET_BITS  (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .data (data_bus),
    .we   (we),
    .oe   (oe),
    .found(found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [13:0] a, input logic [15:0] d);
    addr    = a;
    drv_val = d;
    drv_en  = 1'b1;
    we      = 1'b1;
    oe      = 1'b0;
    @(posedge clk);
    #1;
    we     = 1'b0;
    drv_en = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [13:0] a,
                         input logic exp_found, input logic [15:0] exp_data);
    addr   = a;
    drv_en = 1'b0;
    we     = 1'b0;
    oe     = 1'b1;
    #2;
    check({name, "_found"}, {31'd0, found}, {31'd0, exp_found});
    check({name, "_data"}, {16'd0, data_bus}, {16'd0, exp_data});
    @(posedge clk);
    #1;
    oe = 1'b0;
  endtask

  logic [13:0] post_rst_addrs [7];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    we      = 1'b0;
    oe      = 1'b0;
    addr    = '0;
    drv_en  = 1'b0;
    drv_val = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    do_read("rst_10D", 14'h10D, 1'b0, 16'h0000);

    // Write then read next cycle; neighbouring set misses
    do_write(14'h10D, 16'h0023);
    do_read("wr_10D", 14'h10D, 1'b1, 16'h0023);
    do_read("miss_10C", 14'h10C, 1'b0, 16'h0000);

    // Eviction in set 5: 0x10D becomes LRU after the 0x00D read hit
    do_write(14'h00D, 16'h0001);
    do_write(14'h10D, 16'h0002);
    do_read("hit_00D", 14'h00D, 1'b1, 16'h0001);
    do_write(14'h20D, 16'h0003);
    do_read("evict_10D", 14'h10D, 1'b0, 16'h0000);
    do_read("keep_00D", 14'h00D, 1'b1, 16'h0001);
    do_read("new_20D", 14'h20D, 1'b1, 16'h0003);

    // Hit overwrite, found independent of we
    do_write(14'h10E, 16'h0000);
    do_write(14'h10C, 16'h0007);
    addr = 14'h10E; drv_val = 16'h0023; drv_en = 1'b1; we = 1'b1; oe = 1'b0;
    #2;
    check("found_during_we", {31'd0, found}, 32'd1);
    @(posedge clk);
    #1;
    we = 1'b0; drv_en = 1'b0;
    do_read("ovw_10E", 14'h10E, 1'b1, 16'h0023);
    do_read("ovw_10C", 14'h10C, 1'b1, 16'h0007);

    // A read miss leaves LRU alone: 0x002 stays LRU and is evicted
    do_write(14'h002, 16'h000A);
    do_write(14'h00A, 16'h000B);
    do_read("lru_hit_00A", 14'h00A, 1'b1, 16'h000B);
    do_read("lru_miss_01A", 14'h01A, 1'b0, 16'h0000);
    do_write(14'h01A, 16'h000C);
    do_read("lru_evict_002", 14'h002, 1'b0, 16'h0000);
    do_read("lru_keep_00A", 14'h00A, 1'b1, 16'h000B);
    do_read("lru_new_01A", 14'h01A, 1'b1, 16'h000C);

    // Bus ownership: we=1,oe=1 with bus released must not show the hit word
    addr = 14'h10E; drv_en = 1'b0; we = 1'b1; oe = 1'b1;
    #2;
    check("no_drive_we_oe", {31'd0, (data_bus !== 16'h0023)}, 32'd1);
    we = 1'b0;
    #1;
    check("drive_on_read", {16'd0, data_bus}, 32'h0023);
    #1;
    oe = 1'b0;
    @(posedge clk);
    #1;
    // Write with oe=1 too: the bench value is what gets stored
    addr = 14'h10E; drv_val = 16'h0055; drv_en = 1'b1; we = 1'b1; oe = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; oe = 1'b0; drv_en = 1'b0;
    do_read("we_oe_write", 14'h10E, 1'b1, 16'h0055);

    // Reset together with a write: everything misses afterwards
    addr = 14'h10B; drv_val = 16'h0099; drv_en = 1'b1; we = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; we = 1'b0; drv_en = 1'b0;
    post_rst_addrs = '{14'h10B, 14'h00D, 14'h20D, 14'h10E, 14'h10C, 14'h00A, 14'h01A};
    for (int i = 0; i < 7; i++) begin
      do_read($sformatf("post_rst_%0h", post_rst_addrs[i]), post_rst_addrs[i], 1'b0, 16'h0000);
    end

    // Cache works again after reset
    do_write(14'h10B, 16'h0044);
    do_read("post_rst_wr", 14'h10B, 1'b1, 16'h0044);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_unit.md
CACHE_UNIT -- requirements
Module: cache_unit

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 14 and set the word-address width.
REQ-002 Parameter DATA_WIDTH SHALL default to 16 and set the data word width.
REQ-003 Parameter SET_BITS SHALL default to 3, giving 8 sets; the tag width is ADDR_WIDTH-SET_BITS (11 bits by default).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port addr, input, ADDR_WIDTH bits: word address for lookup and write.
REQ-007 Port data, inout, DATA_WIDTH bits: write data when we=1; driven by the cache only during a read (oe=1, we=0), high-Z otherwise.
REQ-008 Port we, input, 1 bit: write/allocate strobe.
REQ-009 Port oe, input, 1 bit: read enable.
REQ-010 Port found, output, 1 bit: combinational hit flag for the current addr.

Function
REQ-011 Organisation SHALL be 2-way set-associative, one word per line.
- Index = addr[SET_BITS-1:0]; tag = remaining upper bits.
- Per way per set: valid bit, tag, data word.
- Per set: one LRU bit naming the least-recently-used way.
REQ-012 found SHALL be 1 in the same cycle iff a valid way in the indexed set holds a matching tag, independent of we and oe.
REQ-013 Read (oe=1, we=0) SHALL drive data combinationally with the hit way's word; on a miss it SHALL drive all zeros.
REQ-014 On each rising edge with oe=1, we=0 and a hit, the LRU bit of that set SHALL be set to the way that was not hit; misses leave LRU unchanged.
REQ-015 On each rising edge with we=1 (oe is don't-care), the data bus word SHALL be written as follows.
- Hit: overwrite the hit way's data and set LRU to the other way.
- Miss: fill the victim way, setting valid=1, the new tag and the data, and set LRU to the other way.
- Victim selection: the first invalid way (way0 before way1); if both ways are valid, the LRU way.
REQ-016 we SHALL take priority over oe: when both are 1, the access is a write and the cache SHALL NOT drive data.
REQ-017 Write latency SHALL be one cycle: a read of the same address in the next cycle SHALL return the new word with found=1.
REQ-018 When we=0 and oe=0, the cache SHALL hold all state (valid, tag, data, LRU) and leave data high-Z.
REQ-019 The cache SHALL be write-through and allocate-on-write: it holds no dirty state and never initiates main-memory transfers; the CPU performs the backing-RAM write in parallel.
REQ-020 X or Z on addr SHALL be treated as a miss for found; no write is guaranteed defined in that case.

Reset
REQ-021 While rst=1 at a rising edge, every valid bit and every LRU bit SHALL clear to 0, and writes and LRU updates in that cycle SHALL be ignored.
REQ-022 Data and tag arrays need not be cleared by reset.
REQ-023 After reset, found SHALL be 0 for every address and reads SHALL return 0.
REQ-024 Reset asserted mid-operation SHALL take effect at that same edge, discarding any concurrent write.

Verification
REQ-025 Reset, then read 0x10D -> found=0, data=0x0000.
REQ-026 Write 0x10D=0x0023, next cycle read 0x10D -> found=1, data=0x0023; read 0x10C -> found=0.
REQ-027 Eviction sequence -> 0x10D found=0; 0x00D found=1, data=0x0001; 0x20D found=1, data=0x0003.
- Write 0x00D=0x0001, then write 0x10D=0x0002.
- Read 0x00D (hit).
- Write 0x20D=0x0003 (set 5; 0x10D is LRU and is evicted).
REQ-028 Write 0x10E=0x0000, write 0x10C=0x0007, then write 0x10E=0x0023 -> 0x10E reads 0x0023 and 0x10C still reads 0x0007 (hit overwrite, no eviction).
REQ-029 Fill several sets, pulse rst for one cycle together with we=1 to 0x10B -> every address, including 0x10B, misses afterwards.
REQ-030 Drive we=1, oe=1 with the bench releasing the bus -> data reads Z from the cache; with we=0, oe=1 -> the cache drives data.
